cache_memory: RTL and testbench
===============================

# cache_memory

Storage and lookup core of the L1 data cache: a 1 KiB, 4-way set-associative, write-back, write-allocate array of 16-byte lines with true-LRU replacement, built from an internal `lru_manager` submodule. It sits under `cache_controller`. The controller's FSM uses the combinational hit, miss and evict flags, along with read data and victim information, to sequence its states. All array and LRU state updates on the clock edge of the access cycle.

## Interface
- LINE_SIZE, 16: bytes per line; 4 words; offset = address[3:0], word select = address[3:2].
- CACHE_SIZE, 1024: total data bytes.
- ASSOCIATIVITY, 4: ways per set; gives 16 sets, index = address[7:4], tag = address[31:8] (24 bits).

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- reset, input, 1: synchronous, active-high.
- read, input, 1: read request for the current cycle.
- write, input, 1: write request for the current cycle; has priority if asserted together with read.
- address, input, 32: byte address; bits [1:0] ignored.
- write_data, input, 32: word to store on write.
- read_data, output, 32: hit-way word at address[3:2]; 0 unless read is asserted and the access hits.
- hit, output, 1: lookup hit.
- miss, output, 1: lookup miss.
- evict, output, 1: a miss will replace a valid dirty line.
- evict_data, output, 32: victim word at address[3:2]; 0 when evict is 0.
- evict_address, output, 32: {victim tag, index, address[3:2], 2'b00}; 0 when evict is 0.

## Operation
- Per line state: valid, dirty, 24-bit tag, 4×32-bit data. Per set state: four 2-bit LRU ages held in `lru_manager`.
- Lookup is combinational and active only when read or write is high. hit = any valid way with a matching tag. miss = request active and no hit. hit and miss are never both 1.
- Victim selection on a miss: the lowest-numbered invalid way. If all four ways are valid, the way whose age is 3, taken from lru_manager's `lru_way`.
- evict = miss & victim.valid & victim.dirty. Combinational, same cycle as the miss.
- Write hit at the clock edge:
  - store write_data into the addressed word;
  - set dirty;
  - touch LRU for the hit way.
- Read hit at the clock edge: no data change; touch LRU.
- Write miss at the clock edge (allocate):
  - the victim line becomes valid with the new tag;
  - all words cleared to 0, then write_data is placed in the addressed word;
  - dirty = 1;
  - touch LRU for the victim way.
- Read miss at the clock edge (allocate):
  - the victim line becomes valid with the new tag;
  - data cleared to 0;
  - dirty = 0;
  - touch LRU.
- There is no backing memory port. The controller takes evict_data and evict_address for write-back.
- LRU touch on way w:
  - every way with age < age[w] increments;
  - age[w] = 0;
  - the other ways are unchanged.
  - Ages in a set always form a permutation of 0..3.
- Read and write both high: treated as a write. read_data = 0.

## Timing
- Outputs are purely combinational from the current inputs and state, with zero latency. A request held for N cycles performs N accesses.
- Reset (synchronous, sampled on a rising clk edge) has the following effects:
  - all valid and dirty bits are cleared;
  - each set's LRU ages become way0 = 3, way1 = 2, way2 = 1, way3 = 0;
  - data and tag arrays are not required to clear.
- While reset is high:
  - hit, miss and evict are forced to 0;
  - read_data, evict_data and evict_address are forced to 0;
  - no array or LRU update occurs, even if read or write is high.
- Reset asserted mid-sequence discards any in-flight access. The cycle after reset is released is a clean cold start.
- Back-to-back accesses to the same line: after a miss, the next cycle's access to that line hits.
- Idle (read = write = 0): all outputs are 0 and state holds.

## Test plan
- After reset, write 0xAAAAAAAA to 0x00000000: the write cycle shows miss = 1, evict = 0. Reading 0x00000000 next cycle shows hit = 1, read_data = 0xAAAAAAAA.
- Write 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD to 0x10, 0x20, 0x30, each one miss. Read-back hits return the same values. Reading 0x04 returns 0 (cleared word of the allocated line).
- Write tags 0x000, 0x100, 0x200, 0x300 (set 0), each with distinct data. Each is a miss with evict = 0. A write to 0x400 gives miss = 1, evict = 1, evict_address = 0x00000000, evict_data = the first value written.
- Repeat the set fill, then read 0x000 to make it MRU. A write to 0x400 evicts 0x100: evict_address = 0x00000100.
- Fill set 0 using read misses only, then read 0x400: miss = 1, evict = 0 (clean victim).
- Assert reset with write = 1 held, then release. No allocation occurs during reset. A read of any address afterward misses.

Source files
------------

// File: rtl/cache_memory.sv
// -----------------------------------------------------------------------------
// cache_memory
// Storage and lookup core of the L1 data cache. The array holds 1 KiB of data
// as 16 sets x 4 ways x 16-byte lines. It is write-back and write-allocate,
// and uses true-LRU replacement. The lookup is combinational. Array and LRU
// updates happen on the rising clock edge of the access cycle.
//
// Ports
//   clk           : clock; all state changes on the rising edge
//   reset         : synchronous, active-high
//   read, write   : access request for this cycle; write wins when both are high
//   address[31:0] : byte address (tag = [31:8], index = [7:4], word = [3:2])
//   write_data    : word stored on a write
//   read_data     : hit-way word on a read hit, else 0
//   hit, miss     : lookup result, qualified by an active request
//   evict         : the miss replaces a valid dirty line
//   evict_data    : victim word at address[3:2] when evict, else 0
//   evict_address : {victim tag, index, word, 2'b00} when evict, else 0
// -----------------------------------------------------------------------------

// Per-set true-LRU ages. Each set holds 4 ages packed into 8 bits, with the age
// of way w at [2w+1:2w]. Age 0 is MRU and age 3 is LRU.
module lru_manager (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] set_idx,
    input  logic       touch,
    input  logic [1:0] touch_way,
    output logic [1:0] lru_way
);
    // way0 = 3, way1 = 2, way2 = 1, way3 = 0
    localparam logic [7:0] AGE_RESET = 8'b00_01_10_11;

    logic [7:0] age_q [16];
    logic [7:0] age_d [16];
    logic [7:0] cur_ages;
    logic [7:0] nxt_ages;
    logic [1:0] touch_age;

    always_comb begin
        age_d     = age_q;
        cur_ages  = age_q[set_idx];
        nxt_ages  = cur_ages;
        touch_age = cur_ages[{touch_way, 1'b0} +: 2];
        // Ways that were younger than the touched way each age by one. The
        // ages therefore stay a permutation of 0..3.
        for (int w = 0; w < 4; w++) begin
            if (2'(w) == touch_way)
                nxt_ages[2*w +: 2] = 2'd0;
            else if (cur_ages[2*w +: 2] < touch_age)
                nxt_ages[2*w +: 2] = cur_ages[2*w +: 2] + 2'd1;
        end
        if (touch)
            age_d[set_idx] = nxt_ages;
    end

    always_comb begin
        lru_way = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (age_q[set_idx][2*w +: 2] == 2'd3)
                lru_way = 2'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            age_q <= '{default: AGE_RESET};
        else
            age_q <= age_d;
    end
endmodule

module cache_memory (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        miss,
    output logic        evict,
    output logic [31:0] evict_data,
    output logic [31:0] evict_address
);
    logic [3:0]   valid_q [16];
    logic [3:0]   valid_d [16];
    logic [3:0]   dirty_q [16];
    logic [3:0]   dirty_d [16];
    logic [23:0]  tag_q   [16][4];
    logic [127:0] data_q  [16][4];

    logic [3:0]   idx;
    logic [23:0]  req_tag;
    logic [1:0]   word;
    logic         active;
    logic [3:0]   hit_vec;
    logic         any_hit;
    logic [1:0]   hit_way;
    logic [1:0]   lru_way;
    logic [1:0]   victim_way;
    logic [1:0]   upd_way;
    logic [127:0] line_d;
    logic         unused_addr;

    assign idx         = address[7:4];
    assign req_tag     = address[31:8];
    assign word        = address[3:2];
    assign unused_addr = ^address[1:0];
    assign active      = (read | write) & ~reset;

    lru_manager u_lru (
        .clk       (clk),
        .reset     (reset),
        .set_idx   (idx),
        .touch     (active),
        .touch_way (upd_way),
        .lru_way   (lru_way)
    );

    always_comb begin
        hit_vec = '0;
        hit_way = 2'd0;
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == req_tag);
            if (hit_vec[w])
                hit_way = 2'(w);
        end
        any_hit = |hit_vec;

        // The lowest-numbered invalid way is preferred. The LRU way is used
        // only when the set is full. Scanning from way 3 down to way 0 lets the
        // lowest invalid way win.
        victim_way = lru_way;
        for (int w = 3; w >= 0; w--) begin
            if (!valid_q[idx][w])
                victim_way = 2'(w);
        end
        upd_way = any_hit ? hit_way : victim_way;
    end

    always_comb begin
        hit           = active & any_hit;
        miss          = active & ~any_hit;
        evict         = miss & valid_q[idx][victim_way] & dirty_q[idx][victim_way];
        read_data     = (active && read && !write && any_hit)
                        ? data_q[idx][hit_way][{word, 5'd0} +: 32] : 32'd0;
        evict_data    = evict ? data_q[idx][victim_way][{word, 5'd0} +: 32] : 32'd0;
        evict_address = evict ? {tag_q[idx][victim_way], idx, word, 2'b00} : 32'd0;
    end

    // Next line contents. A hit keeps the old line. An allocation starts from
    // an all-zero line. A write then overlays the addressed word.
    always_comb begin
        line_d  = any_hit ? data_q[idx][upd_way] : 128'd0;
        if (write)
            line_d[{word, 5'd0} +: 32] = write_data;

        valid_d = valid_q;
        dirty_d = dirty_q;
        if (active) begin
            valid_d[idx][upd_way] = 1'b1;
            dirty_d[idx][upd_way] = any_hit ? (dirty_q[idx][upd_way] | write) : write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // NOTE: The tag and data arrays are deliberately left out of reset. The
    // valid bits gate every use of them, so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (active) begin
            data_q[idx][upd_way] <= line_d;
            tag_q[idx][upd_way]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_cache_memory.sv
// -----------------------------------------------------------------------------
// tb_cache_memory
// Self-checking bench for cache_memory. A reference model tracks line contents
// and recency as plain arrays. Recency is a per-way timestamp, and the LRU way
// is the oldest timestamp. Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_cache_memory;
    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;
    logic        miss;
    logic        evict;
    logic [31:0] evict_data;
    logic [31:0] evict_address;

    cache_memory dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .hit           (hit),
        .miss          (miss),
        .evict         (evict),
        .evict_data    (evict_data),
        .evict_address (evict_address)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model
    bit          m_valid [16][4];
    bit          m_dirty [16][4];
    logic [23:0] m_tag   [16][4];
    logic [31:0] m_data  [16][4][4];
    int          m_stamp [16][4];
    int          stamp_ctr;

    // Outputs sampled by the most recent access
    logic        obs_hit, obs_miss, obs_evict;
    logic [31:0] obs_rdata, obs_edata, obs_eaddr;

    task automatic model_reset();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_stamp[s][w] = w;   // way0 is least recently used
            end
        stamp_ctr = 4;
    endtask

    task automatic access(input string name, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          idx, wd, hitw, vic, upd, oldest;
        logic [23:0] tg;
        bit          req, e_hit, e_miss, e_evict;
        logic [31:0] e_rdata, e_edata, e_eaddr;

        @(negedge clk);
        read = rd; write = wr; address = addr; write_data = wdata;
        #1;
        idx = int'(addr[7:4]);
        wd  = int'(addr[3:2]);
        tg  = addr[31:8];
        req = rd | wr;

        hitw = -1;
        for (int w = 0; w < 4; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) hitw = w;
        vic = -1;
        for (int w = 3; w >= 0; w--)
            if (!m_valid[idx][w]) vic = w;
        if (vic < 0) begin
            vic = 0; oldest = m_stamp[idx][0];
            for (int w = 1; w < 4; w++)
                if (m_stamp[idx][w] < oldest) begin vic = w; oldest = m_stamp[idx][w]; end
        end

        e_hit   = req && hitw >= 0;
        e_miss  = req && hitw < 0;
        e_evict = e_miss && m_valid[idx][vic] && m_dirty[idx][vic];
        e_rdata = (rd && !wr && hitw >= 0) ? m_data[idx][hitw][wd] : 32'd0;
        e_edata = e_evict ? m_data[idx][vic][wd] : 32'd0;
        e_eaddr = e_evict ? {m_tag[idx][vic], addr[7:4], addr[3:2], 2'b00} : 32'd0;

        obs_hit = hit; obs_miss = miss; obs_evict = evict;
        obs_rdata = read_data; obs_edata = evict_data; obs_eaddr = evict_address;

        check({name, ".hit"},   {31'd0, hit},   {31'd0, e_hit});
        check({name, ".miss"},  {31'd0, miss},  {31'd0, e_miss});
        check({name, ".evict"}, {31'd0, evict}, {31'd0, e_evict});
        check({name, ".rdata"}, read_data,      e_rdata);
        check({name, ".edata"}, evict_data,     e_edata);
        check({name, ".eaddr"}, evict_address,  e_eaddr);

        if (req) begin
            upd = (hitw >= 0) ? hitw : vic;
            if (hitw < 0) begin
                m_valid[idx][upd] = 1;
                m_tag[idx][upd]   = tg;
                m_dirty[idx][upd] = 0;
                for (int k = 0; k < 4; k++) m_data[idx][upd][k] = 32'd0;
            end
            if (wr) begin
                m_data[idx][upd][wd] = wdata;
                m_dirty[idx][upd]    = 1;
            end
            m_stamp[idx][upd] = stamp_ctr;
            stamp_ctr++;
        end
    endtask

    // Holds reset for n cycles with the given request applied. Every output
    // must read 0 throughout.
    task automatic apply_reset(input int n, input bit rd, input bit wr, input logic [31:0] addr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1; read = rd; write = wr; address = addr; write_data = 32'h5A5A_5A5A;
            #1;
            check("rst.hit",   {31'd0, hit},   32'd0);
            check("rst.miss",  {31'd0, miss},  32'd0);
            check("rst.evict", {31'd0, evict}, 32'd0);
            check("rst.rdata", read_data,      32'd0);
            check("rst.edata", evict_data,     32'd0);
            check("rst.eaddr", evict_address,  32'd0);
        end
        @(negedge clk);
        reset = 1'b0; read = 1'b0; write = 1'b0;
        model_reset();
    endtask

    task automatic fill_set0(input bit use_write);
        for (int t = 0; t < 4; t++) begin
            access("fill", !use_write, use_write, 32'(t) << 8, 32'h1000_0000 + 32'(t));
            check("fill.miss",  {31'd0, obs_miss},  32'd1);
            check("fill.evict", {31'd0, obs_evict}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
        apply_reset(2, 1'b0, 1'b0, 32'd0);

        // Cold write, then a read-back hit
        access("t1w", 0, 1, 32'h0000_0000, 32'hAAAA_AAAA);
        check("t1w.miss",  {31'd0, obs_miss},  32'd1);
        check("t1w.evict", {31'd0, obs_evict}, 32'd0);
        access("t1r", 1, 0, 32'h0000_0000, 32'd0);
        check("t1r.hit",   {31'd0, obs_hit},   32'd1);
        check("t1r.rdata", obs_rdata,          32'hAAAA_AAAA);

        // Different sets, read-back, and a cleared word of an allocated line
        access("t2w", 0, 1, 32'h10, 32'hBBBB_BBBB);
        access("t2w", 0, 1, 32'h20, 32'hCCCC_CCCC);
        access("t2w", 0, 1, 32'h30, 32'hDDDD_DDDD);
        access("t2r", 1, 0, 32'h20, 32'd0);
        check("t2r.rdata", obs_rdata, 32'hCCCC_CCCC);
        access("t2r", 1, 0, 32'h04, 32'd0);
        check("t2r.zero_hit", {31'd0, obs_hit}, 32'd1);
        check("t2r.zero",     obs_rdata,        32'd0);

        // A full dirty set evicts the LRU way, which is way 0
        apply_reset(1, 1'b0, 1'b0, 32'd0);
        fill_set0(1'b1);
        access("t3", 0, 1, 32'h400, 32'hEEEE_EEEE);
        check("t3.evict", {31'd0, obs_evict}, 32'd1);
        check("t3.eaddr", obs_eaddr,          32'h0000_0000);
        check("t3.edata", obs_edata,          32'h1000_0000);

        // Touching 0x000 makes 0x100 the victim
        apply_reset(1, 1'b0, 1'b0, 32'd0);
        fill_set0(1'b1);
        access("t4r", 1, 0, 32'h000, 32'd0);
        access("t4", 0, 1, 32'h400, 32'hFFFF_FFFF);
        check("t4.eaddr", obs_eaddr, 32'h0000_0100);
        check("t4.edata", obs_edata, 32'h1000_0001);

        // Clean victims produce no eviction
        apply_reset(1, 1'b0, 1'b0, 32'd0);
        fill_set0(1'b0);
        access("t5", 1, 0, 32'h400, 32'd0);
        check("t5.miss",  {31'd0, obs_miss},  32'd1);
        check("t5.evict", {31'd0, obs_evict}, 32'd0);

        // A write held high during reset must not allocate
        apply_reset(3, 1'b0, 1'b1, 32'h0000_0000);
        access("t6", 1, 0, 32'h0000_0000, 32'd0);
        check("t6.miss", {31'd0, obs_miss}, 32'd1);

        // Read and write together behave as a write and return no read data
        access("t7", 1, 1, 32'h0000_0008, 32'h1234_5678);
        access("t7r", 1, 0, 32'h0000_0008, 32'd0);
        check("t7r.rdata", obs_rdata, 32'h1234_5678);

        // Randomized traffic over a few tags and sets, so that evictions occur
        for (int i = 0; i < 3000; i++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 99));
            a  = {16'd0, 8'($urandom_range(0, 5)), 4'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if (op < 2)
                apply_reset(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
            else if (op < 10)
                access("idle", 0, 0, a, $urandom);
            else if (op < 15)
                access("rw", 1, 1, a, $urandom);
            else if (op < 55)
                access("rd", 1, 0, a, 32'd0);
            else
                access("wr", 0, 1, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
